uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the TX arbiter and the UART TX controller.
// The master modport is the arbiter's view; the slave modport is the producer/TX-controller view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]   i_Req_Valid;
    logic [8*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   o_Req_Grant;
    logic [IDW-1:0]       o_Grant_Id;
    logic [7:0]           o_Tx_Byte;
    logic                 o_Tx_Ready;
    logic                 i_Tx_Active;
    logic                 i_Tx_Done;
    logic                 o_Busy;

    modport master (
        input  i_Req_Valid, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        output o_Req_Grant, o_Grant_Id, o_Tx_Byte, o_Tx_Ready, o_Busy
    );

    modport slave (
        output i_Req_Valid, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Req_Grant, o_Grant_Id, o_Tx_Byte, o_Tx_Ready, o_Busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX controller among NUM_REQ byte producers.
// Optional feature: define UART_ARB_PRIORITY_EN to make requester 0 strict high priority.
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int GUARD_CYCLES = 0,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GUARD} state_e;

    localparam logic [7:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 8'(GUARD_CYCLES - 1) : 8'd0;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]         guard_cnt_q, guard_cnt_d;
    logic               tx_active_prev_q, tx_done_prev_q;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_ready_q, tx_ready_d;

    logic [NUM_REQ-1:0] scan_mask;
    logic [NUM_REQ-1:0] scan_req;
    logic [IDW-1:0]     cand;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     win_ptr;
    logic               active_rise;
    logic               done_rise;

    assign active_rise = bus.i_Tx_Active & ~tx_active_prev_q;
    assign done_rise   = bus.i_Tx_Done & ~tx_done_prev_q;

    // Scan from the far end back toward rr_ptr so the last hit is the first in round-robin order.
    always_comb begin
        scan_mask = '1;
`ifdef UART_ARB_PRIORITY_EN
        scan_mask[0] = 1'b0;
`endif
        scan_req = bus.i_Req_Valid & scan_mask;
        cand     = '0;
        win_idx  = '0;
        win_ptr  = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (scan_req[cand]) begin
                win_idx = cand;
                win_ptr = IDW'((int'(cand) + 1) % NUM_REQ);
            end
        end
`ifdef UART_ARB_PRIORITY_EN
        if (bus.i_Req_Valid[0]) begin
            win_idx = '0;
            win_ptr = rr_ptr_q;
        end
`endif
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        guard_cnt_d = guard_cnt_q;
        grant_d     = '0;
        grant_id_d  = grant_id_q;
        tx_byte_d   = tx_byte_q;
        tx_ready_d  = tx_ready_q;

        case (state_q)
            IDLE: begin
                if (|bus.i_Req_Valid) begin
                    grant_d[win_idx] = 1'b1;
                    grant_id_d       = win_idx;
                    tx_byte_d        = bus.i_Req_Byte[8*win_idx +: 8];
                    tx_ready_d       = 1'b1;
                    rr_ptr_d         = win_ptr;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                if (active_rise) begin
                    tx_ready_d = 1'b0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    if (GUARD_CYCLES > 0) begin
                        guard_cnt_d = GUARD_LOAD;
                        state_d     = GUARD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GUARD: begin
                if (guard_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            rr_ptr_q         <= '0;
            guard_cnt_q      <= '0;
            tx_active_prev_q <= 1'b0;
            tx_done_prev_q   <= 1'b0;
            grant_q          <= '0;
            grant_id_q       <= '0;
            tx_byte_q        <= '0;
            tx_ready_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            guard_cnt_q      <= guard_cnt_d;
            tx_active_prev_q <= bus.i_Tx_Active;
            tx_done_prev_q   <= bus.i_Tx_Done;
            grant_q          <= grant_d;
            grant_id_q       <= grant_id_d;
            tx_byte_q        <= tx_byte_d;
            tx_ready_q       <= tx_ready_d;
        end
    end

    assign bus.o_Req_Grant = grant_q;
    assign bus.o_Grant_Id  = grant_id_q;
    assign bus.o_Tx_Byte   = tx_byte_q;
    assign bus.o_Tx_Ready  = tx_ready_q;
    assign bus.o_Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with a 5-cycle guard, one without.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus_g ();
    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus_z ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GUARD_CYCLES(5)) dut_g (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_g.master)
    );

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GUARD_CYCLES(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // TX controller model: waits for a load, runs a short frame, then raises done.
    task automatic serve_frame(input bit hold_done, output logic [7:0] b, output int id,
                               output logic [NUM_REQ-1:0] g);
        int waited;
        waited = 0;
        b  = '0;
        id = -1;
        g  = '0;
        while (bus_g.o_Tx_Ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus_g.o_Tx_Ready !== 1'b1) begin
            check("tx_ready_wait", 32'(bus_g.o_Tx_Ready), 1);
            return;
        end
        b  = bus_g.o_Tx_Byte;
        id = int'(bus_g.o_Grant_Id);
        g  = bus_g.o_Req_Grant;
        ticks(2);
        bus_g.i_Tx_Active = 1'b1;
        ticks(3);
        bus_g.i_Tx_Active = 1'b0;
        bus_g.i_Tx_Done   = 1'b1;
        if (!hold_done) begin
            ticks(1);
            bus_g.i_Tx_Done = 1'b0;
        end
    endtask

    // Called on the edge where done rises; counts busy cycles until IDLE.
    task automatic count_guard(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_g.o_Busy !== 1'b1) break;
            n++;
            check("guard_no_ready", 32'(bus_g.o_Tx_Ready), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]         b;
        logic [NUM_REQ-1:0] g;
        int                 id;
        int                 n;

        reset = 1'b1;
        bus_g.i_Req_Valid = '0; bus_g.i_Req_Byte = '0;
        bus_g.i_Tx_Active = 1'b0; bus_g.i_Tx_Done = 1'b0;
        bus_z.i_Req_Valid = '0; bus_z.i_Req_Byte = '0;
        bus_z.i_Tx_Active = 1'b0; bus_z.i_Tx_Done = 1'b0;
        ticks(2);

        check("rst_grant", 32'(bus_g.o_Req_Grant), 0);
        check("rst_id",    32'(bus_g.o_Grant_Id), 0);
        check("rst_byte",  32'(bus_g.o_Tx_Byte), 0);
        check("rst_ready", 32'(bus_g.o_Tx_Ready), 0);
        check("rst_busy",  32'(bus_g.o_Busy), 0);
        reset = 1'b0;

        // No-guard instance: done edge returns to IDLE in one cycle.
        bus_z.i_Req_Byte  = {8'h44, 8'h22, 8'h33, 8'h5A};
        bus_z.i_Req_Valid = 4'b0001;
        ticks(1);
        check("z_grant",  32'(bus_z.o_Req_Grant), 32'h1);
        check("z_byte",   32'(bus_z.o_Tx_Byte), 32'h5A);
        check("z_ready",  32'(bus_z.o_Tx_Ready), 1);
        bus_z.i_Req_Valid = '0;
        ticks(1);
        check("z_pulse",  32'(bus_z.o_Req_Grant), 0);
        bus_z.i_Tx_Active = 1'b1;
        ticks(1);
        check("z_ready_clr", 32'(bus_z.o_Tx_Ready), 0);
        check("z_busy_wait", 32'(bus_z.o_Busy), 1);
        bus_z.i_Tx_Active = 1'b0;
        bus_z.i_Tx_Done   = 1'b1;
        bus_z.i_Req_Valid = 4'b0010;
        ticks(1);
        check("z_idle", 32'(bus_z.o_Busy), 0);
        check("z_no_grant_yet", 32'(bus_z.o_Req_Grant), 0);
        bus_z.i_Tx_Done = 1'b0;
        ticks(1);
        check("z_grant2", 32'(bus_z.o_Req_Grant), 32'h2);
        check("z_id2",    32'(bus_z.o_Grant_Id), 1);
        check("z_byte2",  32'(bus_z.o_Tx_Byte), 32'h33);
        bus_z.i_Req_Valid = '0;

        // Single request on requester 1, then the 5-cycle guard.
        bus_g.i_Req_Byte  = {8'h13, 8'h12, 8'hA5, 8'h10};
        bus_g.i_Req_Valid = 4'b0010;
        ticks(1);
        check("t1_grant", 32'(bus_g.o_Req_Grant), 32'h2);
        check("t1_byte",  32'(bus_g.o_Tx_Byte), 32'hA5);
        check("t1_id",    32'(bus_g.o_Grant_Id), 1);
        check("t1_ready", 32'(bus_g.o_Tx_Ready), 1);
        check("t1_busy",  32'(bus_g.o_Busy), 1);
        bus_g.i_Req_Valid = '0;
        ticks(1);
        check("t1_pulse", 32'(bus_g.o_Req_Grant), 0);
        ticks(3);
        check("t1_ready_hold", 32'(bus_g.o_Tx_Ready), 1);
        check("t1_byte_hold",  32'(bus_g.o_Tx_Byte), 32'hA5);
        bus_g.i_Tx_Active = 1'b1;
        ticks(1);
        check("t1_ready_clr", 32'(bus_g.o_Tx_Ready), 0);
        check("t1_busy_wait", 32'(bus_g.o_Busy), 1);
        bus_g.i_Tx_Active = 1'b0;
        bus_g.i_Tx_Done   = 1'b1;
        count_guard(n);
        check("t1_guard_len", 32'(n), 5);
        bus_g.i_Tx_Done = 1'b0;

        // Arbitration order with several requesters held valid.
        reset = 1'b1;
        ticks(1);
        reset = 1'b0;
        bus_g.i_Req_Byte = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef UART_ARB_PRIORITY_EN
        bus_g.i_Req_Valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            serve_frame(1'b0, b, id, g);
            check("prio_id",    32'(id), 0);
            check("prio_byte",  32'(b), 32'h10);
            check("prio_grant", 32'(g), 32'h1);
        end
        bus_g.i_Req_Valid = 4'b0100;
        serve_frame(1'b0, b, id, g);
        check("prio_drop_id",   32'(id), 2);
        check("prio_drop_byte", 32'(b), 32'h12);
`else
        bus_g.i_Req_Valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve_frame(1'b0, b, id, g);
            check("rr_id",    32'(id), 32'(k % 4));
            check("rr_byte",  32'(b), 32'(8'h10 + (k % 4)));
            check("rr_grant", 32'(g), 32'(1 << (k % 4)));
        end
`endif
        bus_g.i_Req_Valid = '0;
        ticks(8);

        // Done held high from a previous frame must not end WAIT_DONE.
        reset = 1'b1;
        ticks(1);
        reset = 1'b0;
        bus_g.i_Req_Valid = 4'b0001;
        serve_frame(1'b1, b, id, g);
        check("hold_byte0", 32'(b), 32'h10);
        bus_g.i_Req_Valid = 4'b0100;
        serve_frame(1'b1, b, id, g);
        check("hold_byte2", 32'(b), 32'h12);
        check("hold_id2",   32'(id), 2);
        bus_g.i_Req_Valid = 4'b0010;
        ticks(30);
        check("hold_busy",     32'(bus_g.o_Busy), 1);
        check("hold_no_ready", 32'(bus_g.o_Tx_Ready), 0);
        check("hold_no_grant", 32'(bus_g.o_Req_Grant), 0);
        bus_g.i_Tx_Done = 1'b0;
        ticks(1);
        bus_g.i_Tx_Done = 1'b1;
        count_guard(n);
        check("hold_guard_len", 32'(n), 5);
        bus_g.i_Tx_Done = 1'b0;
        ticks(1);
        check("hold_next_grant", 32'(bus_g.o_Req_Grant), 32'h2);
        check("hold_next_byte",  32'(bus_g.o_Tx_Byte), 32'h11);
        bus_g.i_Req_Valid = '0;

        // Asynchronous reset in WAIT_DONE, then requester 3 wins from rr_ptr 0.
        bus_g.i_Tx_Active = 1'b1;
        ticks(1);
        check("wd_busy",  32'(bus_g.o_Busy), 1);
        check("wd_ready", 32'(bus_g.o_Tx_Ready), 0);
        bus_g.i_Req_Valid = 4'b1000;
        #2 reset = 1'b1;
        #1;
        check("async_grant", 32'(bus_g.o_Req_Grant), 0);
        check("async_id",    32'(bus_g.o_Grant_Id), 0);
        check("async_byte",  32'(bus_g.o_Tx_Byte), 0);
        check("async_ready", 32'(bus_g.o_Tx_Ready), 0);
        check("async_busy",  32'(bus_g.o_Busy), 0);
        @(negedge clk);
        bus_g.i_Tx_Active = 1'b0;
        reset = 1'b0;
        ticks(1);
        check("post_rst_grant", 32'(bus_g.o_Req_Grant), 32'h8);
        check("post_rst_id",    32'(bus_g.o_Grant_Id), 3);
        check("post_rst_byte",  32'(bus_g.o_Tx_Byte), 32'h13);
        bus_g.i_Req_Valid = '0;
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
